mem_port_arbiter: RTL

Arbitrates one single-ported memory between the instruction-fetch requester and the MEM-stage load/store requester. Serializes transactions with a registered FSM, forwards address/data/byte-enables to the memory, and returns read data plus a one-cycle ack to the winner. Produces stall signals to freeze the IF and MEM pipeline stages while their access is pending. Data accesses have priority; a starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port (if_*)
// and the MEM-stage load/store port (d_*). One transaction is in flight at a
// time. Data requests have priority, but after STARVE_LIM consecutive data
// grants with fetch waiting, fetch is forced to win.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   if_req/if_addr    : fetch request (level, held until if_ack) and address
//   if_rdata/if_ack   : fetch read data, valid with the one-cycle if_ack pulse
//   d_req/d_we/d_be   : data request, store select, store byte enables
//   d_addr/d_wdata    : data address and store data
//   d_rdata/d_ack     : load data, valid with the one-cycle d_ack pulse
//   mem_req..mem_wdata: registered request to memory, stable until mem_ack
//   mem_rdata/mem_ack : memory read data and completion strobe
//   stall_if/stall_mem: freeze the IF / MEM stage while their access pends
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       grant_d, grant_i;
  logic       busy;

  assign busy = (state == BUSY_D) || (state == BUSY_I);

  // Acks are registered, so the stalls drop in the same cycle the winner sees
  // its ack; nothing here depends on mem_ack or mem_rdata combinationally.
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req  & ~d_ack;

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    unique case (state)
      IDLE: begin
        // Data wins unless fetch has already been passed over LIM times.
        if (d_req && !(if_req && starve_cnt == LIM)) grant_d = 1'b1;
        else if (if_req)                            grant_i = 1'b1;

        if (!if_req || grant_i)                 starve_nxt = '0;
        else if (grant_d && starve_cnt != LIM)  starve_nxt = starve_cnt + 4'd1;

        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_D, BUSY_I: if (mem_ack) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_be    <= d_we ? d_be : 4'hF;   // loads always read the full word
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_be   <= 4'hF;
        mem_addr <= if_addr;
      end

      // mem_ack outside BUSY_x (late ack after reset, stray pulse) is ignored.
      if (busy && mem_ack) begin
        mem_req <= 1'b0;
        if (state == BUSY_D) begin
          d_rdata <= mem_rdata;
          d_ack   <= 1'b1;
        end else begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end
      end
    end
  end

endmodule
